// File: rtl/spi_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_arbiter
// Purpose  : Round-robin sharing of one SPI master (din/newd/cs) among NREQ
//            requesters, with per-phase timeout and one-cycle ack/err pulses.
// Revision : 1.0  initial release
// ============================================================================
module spi_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [DW-1:0]        spi_din,
  output logic                 spi_newd,
  input  logic                 spi_cs
);

  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_BUSY   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]      state;
  logic [2:0]      rr;
  logic [TW-1:0]   timer;
  logic            cs_q;
  logic            fall;
  logic            rise;
  logic [NREQ-1:0] rot;
  logic [3:0]      sum;
  logic [2:0]      win;
  logic [DW-1:0]   win_word;
  logic [NREQ-1:0] grant_oh;

  assign fall     = cs_q & ~spi_cs;
  assign rise     = ~cs_q & spi_cs;
  assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;

  // Rotate requests so bit 0 is the rr pointer; the lowest set bit wins.
  always_comb begin
    rot = (req >> rr) | (req << (4'(NREQ) - {1'b0, rr}));
    sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr} + 4'(k);
      end
    end
    if (sum >= 4'(NREQ)) begin
      sum = sum - 4'(NREQ);
    end
    win = sum[2:0];
  end

  always_comb begin
    win_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (3'(k) == win) begin
        win_word = req_data[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ack      <= '0;
      err      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      spi_din  <= '0;
      spi_newd <= 1'b0;
      rr       <= '0;
      timer    <= '0;
      cs_q     <= 1'b1;
    end else begin
      cs_q <= spi_cs;
      ack  <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          // A low cs here means someone else owns the master; wait it out.
          if ((|req) && spi_cs) begin
            grant_id <= win;
            spi_din  <= win_word;
            rr       <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
            timer    <= '0;
            spi_newd <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (fall) begin
            spi_newd <= 1'b0;
            timer    <= '0;
            state    <= S_BUSY;
          end else if (timer == TLAST) begin
            spi_newd <= 1'b0;
            timer    <= '0;
            err      <= grant_oh;
            state    <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_BUSY: begin
          // newd stays low so the master does not restart when cs returns high.
          if (rise) begin
            timer <= '0;
            ack   <= grant_oh;
            state <= S_DONE;
          end else if (timer == TLAST) begin
            timer <= '0;
            err   <= grant_oh;
            state <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DONE, S_ERR: begin
          timer <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          spi_newd <= 1'b0;
          busy     <= 1'b0;
          timer    <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_arbiter.sv
`default_nettype none
// Bench for spi_tx_arbiter: random clients and a behavioural SPI master,
// checked against a transaction-level model of arbitration, timing and timeouts.
module tb_spi_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 64;

  localparam int P_IDLE   = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_BUSY   = 2;
  localparam int P_END    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     ack;
  logic [NREQ-1:0]     err;
  logic                busy;
  logic [2:0]          grant_id;
  logic [DW-1:0]       spi_din;
  logic                spi_newd;
  logic                spi_cs;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] word [NREQ];
  bit            owed [NREQ];
  bit [NREQ-1:0] en_mask;
  bit            timeouts_on;
  int            rr_m, win_m, phase, idx;
  int            m_delay, m_len, low_cnt;
  bit            m_ignore, lowered, raised;
  int            n_ack, n_err;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .grant_id (grant_id),
    .spi_din  (spi_din),
    .spi_newd (spi_newd),
    .spi_cs   (spi_cs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
    logic [NREQ-1:0] s;
    for (int k = 0; k < NREQ; k++) begin
      s = r >> ((start + k) % NREQ);
      if (s[0]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int w);
    return {{(NREQ-1){1'b0}}, 1'b1} << w;
  endfunction

  task automatic client_done(input int w);
    owed[w] = 1'b0;
    req[w]  = 1'b0;
  endtask

  // One clock: observe after the edge, update the model, then act as master and clients.
  task automatic step();
    bit ev_low, ev_high;
    @(posedge clk); #1;
    ev_low  = lowered;
    ev_high = raised;
    lowered = 1'b0;
    raised  = 1'b0;
    idx++;
    case (phase)
      P_END: begin
        phase = P_IDLE;
        idx   = 0;
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_ack", 32'(ack), 32'(0));
        chk("idle_err", 32'(err), 32'(0));
        chk("idle_newd", 32'(spi_newd), 32'(0));
      end
      P_IDLE: begin
        if (req != '0 && spi_cs) begin
          win_m = pick(req, rr_m);
          rr_m  = (win_m + 1) % NREQ;
          chk("launch_newd", 32'(spi_newd), 32'(1));
          chk("launch_busy", 32'(busy), 32'(1));
          chk("grant", 32'(grant_id), 32'(win_m));
          chk("launch_din", 32'(spi_din), 32'(word[win_m]));
          phase    = P_LAUNCH;
          idx      = 0;
          m_ignore = timeouts_on && ($urandom_range(0, 11) == 0);
          m_delay  = int'($urandom_range(0, 2));
        end else begin
          chk("idle_newd", 32'(spi_newd), 32'(0));
          chk("idle_busy", 32'(busy), 32'(0));
        end
        chk("idle_ack", 32'(ack), 32'(0));
        chk("idle_err", 32'(err), 32'(0));
      end
      P_LAUNCH: begin
        if (ev_low) begin
          chk("fall_newd", 32'(spi_newd), 32'(0));
          chk("fall_busy", 32'(busy), 32'(1));
          chk("fall_err", 32'(err), 32'(0));
          phase = P_BUSY;
          idx   = 0;
        end else if (idx == TIMEOUT) begin
          chk("launch_timeout_err", 32'(err), 32'(oh(win_m)));
          chk("launch_timeout_newd", 32'(spi_newd), 32'(0));
          chk("launch_timeout_busy", 32'(busy), 32'(1));
          n_err++;
          phase = P_END;
          client_done(win_m);
        end else begin
          chk("launch_hold_newd", 32'(spi_newd), 32'(1));
          chk("launch_hold_err", 32'(err), 32'(0));
          chk("launch_hold_din", 32'(spi_din), 32'(word[win_m]));
        end
        chk("launch_ack", 32'(ack), 32'(0));
      end
      P_BUSY: begin
        if (ev_high) begin
          chk("ack", 32'(ack), 32'(oh(win_m)));
          chk("ack_err", 32'(err), 32'(0));
          chk("ack_busy", 32'(busy), 32'(1));
          n_ack++;
          phase = P_END;
          client_done(win_m);
        end else if (idx == TIMEOUT) begin
          chk("busy_timeout_err", 32'(err), 32'(oh(win_m)));
          chk("busy_timeout_ack", 32'(ack), 32'(0));
          n_err++;
          phase = P_END;
          client_done(win_m);
        end else begin
          chk("busy_newd", 32'(spi_newd), 32'(0));
          chk("busy_busy", 32'(busy), 32'(1));
          chk("busy_ack", 32'(ack | err), 32'(0));
          chk("busy_din", 32'(spi_din), 32'(word[win_m]));
          chk("busy_grant", 32'(grant_id), 32'(win_m));
        end
      end
      default: chk("phase", 32'(phase), 32'(P_IDLE));
    endcase

    if (phase == P_LAUNCH && !m_ignore && idx == m_delay && spi_cs) begin
      spi_cs  = 1'b0;
      lowered = 1'b1;
      low_cnt = 0;
      m_len   = (timeouts_on && $urandom_range(0, 11) == 0) ? TIMEOUT + 6
                                                             : 24 + int'($urandom_range(0, 8));
    end else if (!spi_cs) begin
      low_cnt++;
      if (low_cnt == m_len) begin
        spi_cs = 1'b1;
        raised = 1'b1;
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (owed[i] && phase == P_BUSY && i == win_m && req[i] && $urandom_range(0, 15) == 0) begin
        req[i] = 1'b0;
      end else if (!owed[i] && en_mask[i] && $urandom_range(0, 3) == 0) begin
        word[i]                = DW'($urandom);
        req_data[i*DW +: DW]   = word[i];
        req[i]                 = 1'b1;
        owed[i]                = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) begin
      owed[i] = 1'b0;
      word[i] = '0;
    end
    req      = '0;
    req_data = '0;
    spi_cs   = 1'b1;
    rr_m     = 0;
    phase    = P_IDLE;
    idx      = 0;
    lowered  = 1'b0;
    raised   = 1'b0;
    m_ignore = 1'b0;
    low_cnt  = 0;
    m_len    = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'(0));
    chk({tag, "_err"}, 32'(err), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_grant"}, 32'(grant_id), 32'(0));
    chk({tag, "_din"}, 32'(spi_din), 32'(0));
    chk({tag, "_newd"}, 32'(spi_newd), 32'(0));
  endtask

  initial begin
    int n;
    int acks_before;
    rst         = 1'b0;
    en_mask     = '1;
    timeouts_on = 1'b1;
    n_ack       = 0;
    n_err       = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    repeat (3000) step();
    chk("acks_seen", 32'(n_ack > 40), 32'(1));
    chk("errs_seen", 32'(n_err > 0), 32'(1));

    // Abort a transfer in the middle of the shift phase.
    n = 0;
    while (!(phase == P_BUSY && idx == 5) && n < 2000) begin
      step();
      n++;
    end
    chk("reach_busy", 32'(phase == P_BUSY && idx == 5), 32'(1));
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    model_clear();
    en_mask     = 4'b1000;
    timeouts_on = 1'b0;
    word[3]     = 12'h3C5;
    req_data[3*DW +: DW] = word[3];
    req[3]      = 1'b1;
    owed[3]     = 1'b1;
    acks_before = n_ack;
    rst         = 1'b1;
    repeat (300) step();
    chk("post_reset_ack", 32'(n_ack > acks_before), 32'(1));

    en_mask     = '1;
    timeouts_on = 1'b1;
    repeat (1500) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
